// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared state type and command-field constants for uart_reg_bridge
package uart_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DATA,
      SEND,
      WAIT_DONE
   } state_t;

   localparam int               WR_BIT      = 7;
   localparam int               ADDR_MSB    = 2;
   localparam logic [7:0]       RSVD_MASK   = 8'h78;
   localparam logic [ADDR_MSB:0] STATUS_ADDR = 3'd7;
   localparam logic [7:0]       DEFAULT_ACK = 8'hAA;
   localparam logic [7:0]       DEFAULT_ERR = 8'hEE;

   function automatic logic is_writable(input logic [ADDR_MSB:0] addr, input int num_regs);
      return int'(addr) < num_regs;
   endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// rtl/uart_reg_bridge.sv - UART byte command engine: host read/write of a small register file, one reply per command
module uart_reg_bridge
   import uart_bridge_pkg::*;
#(
   parameter int         NUM_WR_REGS  = 4,
   parameter int         TIMEOUT_CLKS = 2400000,
   parameter logic [7:0] ACK_BYTE     = DEFAULT_ACK,
   parameter logic [7:0] ERR_BYTE     = DEFAULT_ERR
) (
   input  logic        CLK,
   input  logic        nRst,
   input  logic        i_rx_dv,
   input  logic [7:0]  i_rx_byte,
   output logic        o_tx_dv,
   output logic [7:0]  o_tx_byte,
   input  logic        i_tx_active,
   input  logic        i_tx_done,
   input  logic [7:0]  i_status,
   output logic [31:0] o_regs,
   output logic [3:0]  o_wr_strobe,
   output logic        o_overrun
);

   localparam int            CW      = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [7:0]        r_regs [4];
   logic [7:0]        r_tx_byte;
   logic              r_tx_dv;
   logic [ADDR_MSB:0] r_addr;
   logic [CW-1:0]     r_cnt;
   logic [3:0]        r_wr_strobe;
   logic              r_overrun;

   logic [ADDR_MSB:0] w_cmd_addr;
   logic [7:0]        w_rd_data;
   logic [7:0]        w_tx_byte;
   logic              w_latch_addr;
   logic              w_wr_en;
   logic              w_set_dv;
   logic              w_clr_dv;
   logic              w_overrun;

   assign w_cmd_addr = i_rx_byte[ADDR_MSB:0];

   always_comb begin
      w_rd_data = ERR_BYTE;
      if (w_cmd_addr == STATUS_ADDR) begin
         w_rd_data = i_status;
      end else if (is_writable(w_cmd_addr, NUM_WR_REGS)) begin
         w_rd_data = r_regs[w_cmd_addr[1:0]];
      end
   end

   always_ff @(posedge CLK or negedge nRst) begin
      if (!nRst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_tx_byte    = r_tx_byte;
      w_latch_addr = 1'b0;
      w_wr_en      = 1'b0;
      w_set_dv     = 1'b0;
      w_clr_dv     = 1'b0;
      w_overrun    = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_rx_dv) begin
               if ((i_rx_byte & RSVD_MASK) != 8'h00) begin
                  w_tx_byte    = ERR_BYTE;
                  w_next_state = SEND;
               end else if (i_rx_byte[WR_BIT]) begin
                  // Unmapped write addresses are only rejected once the data byte arrives
                  w_latch_addr = 1'b1;
                  w_next_state = WAIT_DATA;
               end else begin
                  w_tx_byte    = w_rd_data;
                  w_next_state = SEND;
               end
            end
         end
         WAIT_DATA: begin
            if (i_rx_dv) begin
               if (is_writable(r_addr, NUM_WR_REGS)) begin
                  w_wr_en   = 1'b1;
                  w_tx_byte = ACK_BYTE;
               end else begin
                  w_tx_byte = ERR_BYTE;
               end
               w_next_state = SEND;
            end else if (r_cnt == TO_LAST) begin
               w_next_state = IDLE;
            end
         end
         SEND: begin
            w_overrun = i_rx_dv;
            if (!i_tx_active) begin
               w_set_dv     = 1'b1;
               w_next_state = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            w_overrun = i_rx_dv;
            if (i_tx_done) begin
               w_clr_dv     = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRst) begin
      if (!nRst) begin
         r_tx_byte   <= '0;
         r_tx_dv     <= 1'b0;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_wr_strobe <= '0;
         r_overrun   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_tx_byte   <= w_tx_byte;
         r_overrun   <= w_overrun;
         r_wr_strobe <= '0;
         if (w_set_dv) begin
            r_tx_dv <= 1'b1;
         end else if (w_clr_dv) begin
            r_tx_dv <= 1'b0;
         end
         if (w_latch_addr) begin
            r_addr <= w_cmd_addr;
            r_cnt  <= '0;
         end else if (r_state == WAIT_DATA) begin
            r_cnt <= r_cnt + CW'(1);
         end
         // Register update and its strobe land in the same cycle, ahead of the ACK
         if (w_wr_en) begin
            r_regs[r_addr[1:0]] <= i_rx_byte;
            r_wr_strobe         <= 4'b0001 << r_addr[1:0];
         end
      end
   end

   assign o_tx_dv     = r_tx_dv;
   assign o_tx_byte   = r_tx_byte;
   assign o_regs      = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
   assign o_wr_strobe = r_wr_strobe;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb/tb_uart_reg_bridge.sv - scoreboard bench for uart_reg_bridge
module tb_uart_reg_bridge;

   localparam int TO = 100;

   logic        CLK = 1'b0;
   logic        nRst = 1'b0;
   logic        i_rx_dv = 1'b0;
   logic [7:0]  i_rx_byte = 8'h00;
   logic        o_tx_dv;
   logic [7:0]  o_tx_byte;
   logic        i_tx_active = 1'b0;
   logic        i_tx_done = 1'b0;
   logic [7:0]  i_status = 8'h00;
   logic [31:0] o_regs;
   logic [3:0]  o_wr_strobe;
   logic        o_overrun;

   always #5 CLK = ~CLK;

   uart_reg_bridge #(.NUM_WR_REGS(4), .TIMEOUT_CLKS(TO)) dut (
      .CLK(CLK), .nRst(nRst),
      .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
      .i_tx_active(i_tx_active), .i_tx_done(i_tx_done),
      .i_status(i_status), .o_regs(o_regs),
      .o_wr_strobe(o_wr_strobe), .o_overrun(o_overrun)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  model_regs [4];
   int          strobe_cnt = 0;
   logic [3:0]  strobe_last = 4'b0;
   int          overrun_cnt = 0;

   always @(negedge CLK) begin
      if (o_wr_strobe != 4'b0) begin
         strobe_cnt  = strobe_cnt + 1;
         strobe_last = o_wr_strobe;
      end
      if (o_overrun) overrun_cnt = overrun_cnt + 1;
   end

   function automatic logic [7:0] exp_read(input logic [2:0] a);
      if (a == 3'd7) return i_status;
      if (a < 3'd4) return model_regs[a[1:0]];
      return 8'hEE;
   endfunction

   function automatic logic [31:0] model_packed();
      return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      i_rx_byte = b;
      i_rx_dv   = 1'b1;
      @(posedge CLK); #1;
      i_rx_dv   = 1'b0;
   endtask

   // Called right after the command's final send_byte; returns with DUT in WAIT_DONE
   task automatic wait_reply(input string name, input bit chk_lat);
      int         cyc;
      logic [7:0] exp;
      cyc = 1;
      while (!o_tx_dv && cyc < 200) begin
         @(posedge CLK); #1;
         cyc++;
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_vec++;
      if (o_tx_dv !== 1'b1) begin
         n_err++;
         $display("FAIL %s_dv: o_tx_dv=%b after %0d cycles, required 1", name, o_tx_dv, cyc);
         return;
      end
      if (chk_lat) begin
         n_vec++;
         if (cyc !== 2) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles, required 2", name, cyc);
         end
      end
      n_vec++;
      if (o_tx_byte !== exp) begin
         n_err++;
         $display("FAIL %s_byte: o_tx_byte=%h, required %h", name, o_tx_byte, exp);
      end
      repeat (3) begin @(posedge CLK); #1; end
      n_vec++;
      if (o_tx_dv !== 1'b1 || o_tx_byte !== exp) begin
         n_err++;
         $display("FAIL %s_hold: o_tx_dv=%b o_tx_byte=%h, required 1 %h", name, o_tx_dv, o_tx_byte, exp);
      end
   endtask

   task automatic finish_reply(input string name);
      i_tx_done = 1'b1;
      @(posedge CLK); #1;
      i_tx_done = 1'b0;
      n_vec++;
      if (o_tx_dv !== 1'b0) begin
         n_err++;
         $display("FAIL %s_release: o_tx_dv=%b, required 0", name, o_tx_dv);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
      nRst = 1'b0;
      repeat (2) begin @(posedge CLK); #1; end
      n_vec++;
      if ({o_tx_dv, o_tx_byte, o_wr_strobe, o_overrun} !== 14'h0 || o_regs !== 32'h0) begin
         n_err++;
         $display("FAIL reset: dv=%b byte=%h strobe=%b ovr=%b regs=%h, required all 0",
                  o_tx_dv, o_tx_byte, o_wr_strobe, o_overrun, o_regs);
      end
      nRst = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_write_reg1();
      int s0;
      s0 = strobe_cnt;
      exp_q.push_back(8'hAA);
      send_byte(8'h81);
      send_byte(8'h5A);
      model_regs[1] = 8'h5A;
      n_vec++;
      if (o_wr_strobe !== 4'b0010 || o_regs[15:8] !== 8'h5A) begin
         n_err++;
         $display("FAIL wr1_update: strobe=%b reg1=%h, required 0010 5a", o_wr_strobe, o_regs[15:8]);
      end
      wait_reply("wr1", 1'b1);
      finish_reply("wr1");
      n_vec++;
      if (strobe_cnt - s0 !== 1) begin
         n_err++;
         $display("FAIL wr1_strobe_count: %0d pulses, required 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_read_back();
      exp_q.push_back(exp_read(3'd1));
      send_byte(8'h01);
      wait_reply("rd1", 1'b1);
      finish_reply("rd1");
      i_status = 8'h0C;
      exp_q.push_back(exp_read(3'd7));
      send_byte(8'h07);
      wait_reply("rd_status", 1'b1);
      finish_reply("rd_status");
   endtask

   task automatic test_errors();
      int s0;
      exp_q.push_back(8'hEE);
      send_byte(8'h41);
      wait_reply("err_rsvd", 1'b1);
      finish_reply("err_rsvd");
      exp_q.push_back(exp_read(3'd5));
      send_byte(8'h05);
      wait_reply("err_rd5", 1'b1);
      finish_reply("err_rd5");
      for (int k = 0; k < 2; k++) begin
         s0 = strobe_cnt;
         exp_q.push_back(8'hEE);
         send_byte(k == 0 ? 8'h86 : 8'h87);
         send_byte(8'h11);
         wait_reply("err_wr_unmapped", 1'b1);
         finish_reply("err_wr_unmapped");
         n_vec++;
         if (strobe_cnt !== s0 || o_regs !== model_packed()) begin
            n_err++;
            $display("FAIL err_wr_side_effect: strobes=%0d regs=%h, required %0d %h",
                     strobe_cnt, o_regs, s0, model_packed());
         end
      end
   endtask

   task automatic test_write_all();
      logic [7:0] vals [4];
      vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h96; vals[3] = 8'h69;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'hAA);
         send_byte(8'h80 | 8'(i));
         send_byte(vals[i]);
         model_regs[i] = vals[i];
         wait_reply("wr_all", 1'b0);
         finish_reply("wr_all");
         n_vec++;
         if (strobe_last !== (4'b0001 << i)) begin
            n_err++;
            $display("FAIL wr_all_strobe: reg %0d strobe=%b, required %b", i, strobe_last, 4'b0001 << i);
         end
      end
      for (int i = 3; i >= 0; i--) begin
         exp_q.push_back(exp_read(3'(i)));
         send_byte(8'(i));
         wait_reply("rd_all", 1'b0);
         finish_reply("rd_all");
      end
      n_vec++;
      if (o_regs !== model_packed()) begin
         n_err++;
         $display("FAIL wr_all_regs: o_regs=%h, required %h", o_regs, model_packed());
      end
   endtask

   task automatic test_timeout();
      bit dv_seen;
      dv_seen = 1'b0;
      send_byte(8'h80);
      repeat (TO) begin
         @(posedge CLK); #1;
         if (o_tx_dv) dv_seen = 1'b1;
      end
      n_vec++;
      if (dv_seen) begin
         n_err++;
         $display("FAIL timeout_silent: o_tx_dv seen=1, required 0");
      end
      exp_q.push_back(exp_read(3'd0));
      send_byte(8'h00);
      wait_reply("timeout_next_is_cmd", 1'b1);
      finish_reply("timeout_next_is_cmd");
      // Data byte on the final timeout cycle must still be taken as data
      exp_q.push_back(8'hAA);
      send_byte(8'h82);
      repeat (TO - 1) @(posedge CLK);
      #1;
      send_byte(8'h7E);
      model_regs[2] = 8'h7E;
      wait_reply("timeout_byte_wins", 1'b1);
      finish_reply("timeout_byte_wins");
      n_vec++;
      if (o_regs !== model_packed()) begin
         n_err++;
         $display("FAIL timeout_byte_wins_regs: o_regs=%h, required %h", o_regs, model_packed());
      end
   endtask

   task automatic test_back_to_back();
      int ov0;
      i_tx_active = 1'b1;
      exp_q.push_back(exp_read(3'd0));
      send_byte(8'h00);
      repeat (5) begin @(posedge CLK); #1; end
      n_vec++;
      if (o_tx_dv !== 1'b0) begin
         n_err++;
         $display("FAIL bp_wait: o_tx_dv=%b while tx active, required 0", o_tx_dv);
      end
      ov0 = overrun_cnt;
      send_byte(8'h82);
      @(posedge CLK); #1;
      n_vec++;
      if (overrun_cnt - ov0 !== 1) begin
         n_err++;
         $display("FAIL ovr_send: %0d overrun pulses, required 1", overrun_cnt - ov0);
      end
      i_tx_active = 1'b0;
      wait_reply("bp", 1'b0);
      ov0 = overrun_cnt;
      send_byte(8'h81);
      @(posedge CLK); #1;
      n_vec++;
      if (overrun_cnt - ov0 !== 1 || o_tx_dv !== 1'b1 || o_tx_byte !== model_regs[0]
          || o_regs !== model_packed()) begin
         n_err++;
         $display("FAIL ovr_wait_done: pulses=%0d dv=%b byte=%h regs=%h, required 1 1 %h %h",
                  overrun_cnt - ov0, o_tx_dv, o_tx_byte, o_regs, model_regs[0], model_packed());
      end
      finish_reply("bp");
      exp_q.push_back(exp_read(3'd1));
      send_byte(8'h01);
      wait_reply("bp_after", 1'b1);
      finish_reply("bp_after");
   endtask

   task automatic test_reset_mid_write();
      send_byte(8'h82);
      #2;
      nRst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
      n_vec++;
      if ({o_tx_dv, o_tx_byte, o_wr_strobe, o_overrun} !== 14'h0 || o_regs !== 32'h0) begin
         n_err++;
         $display("FAIL reset_mid: dv=%b byte=%h strobe=%b ovr=%b regs=%h, required all 0",
                  o_tx_dv, o_tx_byte, o_wr_strobe, o_overrun, o_regs);
      end
      @(posedge CLK); #1;
      nRst = 1'b1;
      exp_q.push_back(8'hEE);
      send_byte(8'h33);
      wait_reply("post_reset_cmd", 1'b1);
      finish_reply("post_reset_cmd");
      exp_q.push_back(exp_read(3'd2));
      send_byte(8'h02);
      wait_reply("post_reset_rd2", 1'b1);
      finish_reply("post_reset_rd2");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_reg1();
      test_read_back();
      test_errors();
      test_write_all();
      test_timeout();
      test_back_to_back();
      test_reset_mid_write();
      n_vec++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
